fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 18, framebuffer word-address width (472x472 = 222784 pixels fit in 2^18).
REQ-002 The block SHALL have parameter DATA_W, default 4, bits per pixel word.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries, power of two, at least 2.
REQ-004 clk25  input  1  pixel clock, 25 MHz; one clock only, all logic on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 vid_req  input  1  scanout read request, one per cycle during active video.
REQ-007 vid_addr  input  ADDR_W  scanout read address.
REQ-008 vid_rdata  output  DATA_W  scanout read data.
REQ-009 vid_rvalid  output  1  vid_rdata valid.
REQ-010 wr_valid  input  1  writer request.
REQ-011 wr_ready  output  1  writer accept.
REQ-012 wr_addr  input  ADDR_W  write address.
REQ-013 wr_data  input  DATA_W  write data.
REQ-014 mem_en, mem_we  output  1 each  RAM port enable and write enable.
REQ-015 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W  single-port synchronous RAM, read data one cycle after the enabled read.
REQ-016 fifo_level  output  $clog2(FIFO_DEPTH)+1  write-buffer occupancy.

Function
REQ-017 A write transfer SHALL occur in a cycle with wr_valid and wr_ready both high; the transfer pushes {wr_addr, wr_data} into the FIFO.
REQ-018 wr_ready SHALL equal (fifo_level != FIFO_DEPTH), derived from registered count only, with no dependency on wr_valid.
REQ-019 Arbitration per cycle: vid_req high grants video a read; otherwise, if the FIFO is non-empty, a FIFO write is granted and popped; otherwise the RAM port idles.
REQ-020 Video SHALL have strict priority; a write SHALL never delay or drop a video read.
REQ-021 mem_en, mem_we, mem_addr and mem_wdata SHALL be registered: a grant decided in cycle T drives the RAM in cycle T+1; an idle grant drives mem_en=0, mem_we=0.
REQ-022 vid_rvalid SHALL be high exactly in cycle T+2 for each vid_req in cycle T, with vid_rdata = mem_rdata in that cycle; vid_rdata SHALL be 0 whenever vid_rvalid is low.
REQ-023 Push and pop in the same cycle SHALL leave fifo_level unchanged; push at full is impossible by REQ-018; pop at empty is never granted.
REQ-024 No bypass: a word pushed in cycle T is popped no earlier than cycle T+1.
REQ-025 FIFO writes SHALL reach the RAM in push order; a video read of an address still in the FIFO returns the old RAM content (no forwarding).

Reset
REQ-026 While reset_n is low: FIFO empty, fifo_level=0, wr_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, vid_rvalid=0, vid_rdata=0, statistics zero.
REQ-027 Reset mid-operation SHALL discard buffered writes and in-flight reads; wr_ready SHALL rise in the first clk25 cycle after reset_n deasserts.

Configuration
REQ-028 With FB_ARB_STATS_EN defined: outputs stat_wr_count (16 bits, RAM writes issued, wraps at 65535->0) and stat_max_stall (8 bits, longest run of consecutive cycles with FIFO non-empty and vid_req high, saturating at 255); both registered and cleared only by reset.
REQ-029 Without FB_ARB_STATS_EN: these ports and their counters SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package fb_arb_pkg SHALL hold FB_W=472, FB_H=472, default ADDR_W, DATA_W, FIFO_DEPTH and the write-entry struct type {addr, data}.
REQ-031 Sub-module fb_wr_fifo SHALL implement the synchronous FIFO (push, pop, full, empty, level); fb_arbiter holds the grant logic, RAM registers, read-valid pipeline and statistics.

Verification
REQ-032 Idle, single write addr=0x00010 data=0xF: RAM write at cycle T+2 after the push (mem_en=1, mem_we=1); fifo_level returns to 0.
REQ-033 vid_req held high for 472 cycles while 6 writes are offered: wr_ready drops after 4 accepted, no RAM write during the burst, vid_rvalid high for exactly 472 cycles starting 2 cycles after the first vid_req.
REQ-034 Push and pop in the same cycle at fifo_level=2: level stays 2; all writes reach the RAM in push order.
REQ-035 reset_n pulsed low with 3 writes buffered and 2 reads in flight: level 0, vid_rvalid 0, no RAM access; wr_ready=1 the cycle after release.
REQ-036 FB_ARB_STATS_EN defined, 300-cycle vid_req burst with FIFO non-empty: stat_max_stall=255; stat_wr_count increments once per RAM write.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared constants and types for the framebuffer arbiter: screen geometry,
// default widths and the buffered write entry layout.
package fb_arb_pkg;

  localparam int FB_W           = 472;
  localparam int FB_H           = 472;
  localparam int ADDR_W_DEF     = 18;
  localparam int DATA_W_DEF     = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  // Write entry at the default geometry; the arbiter re-declares it at its own widths.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write-buffer FIFO with registered occupancy; read data shows
// the head entry combinationally and a push is never visible before the next cycle.
module fb_wr_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                     clk25,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array has no reset; pointers and level alone decide what is valid.
  always_ff @(posedge clk25) begin
    if (push) store[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
    end
  end

  assign rdata = store[rd_ptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: scanout reads have strict priority,
// writer traffic is buffered and drained in idle slots. Define FB_ARB_STATS_EN
// to add the write counter and longest-stall statistics outputs.
module fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk25,
  input  logic                          reset_n,
  input  logic                          vid_req,
  input  logic [ADDR_W-1:0]             vid_addr,
  output logic [DATA_W-1:0]             vid_rdata,
  output logic                          vid_rvalid,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
`ifdef FB_ARB_STATS_EN
  output logic [15:0]                   stat_wr_count,
  output logic [7:0]                    stat_max_stall,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            push_entry;
  entry_t            head;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              ready_en;
  logic [1:0]        rd_pipe;
  logic              nxt_en;
  logic              nxt_we;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_wdata;

  assign push_entry = '{addr: wr_addr, data: wr_data};
  assign wr_ready   = ready_en && !full;
  assign push       = wr_valid && wr_ready;
  assign pop        = !vid_req && !empty;

  fb_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk25   (clk25),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (push_entry),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // Holds wr_ready low through reset and releases it on the first edge after.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    nxt_en    = 1'b0;
    nxt_we    = 1'b0;
    nxt_addr  = '0;
    nxt_wdata = '0;
    if (vid_req) begin
      nxt_en   = 1'b1;
      nxt_addr = vid_addr;
    end else if (pop) begin
      nxt_en    = 1'b1;
      nxt_we    = 1'b1;
      nxt_addr  = head.addr;
      nxt_wdata = head.data;
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_pipe   <= 2'b00;
    end else begin
      mem_en    <= nxt_en;
      mem_we    <= nxt_we;
      mem_addr  <= nxt_addr;
      mem_wdata <= nxt_wdata;
      rd_pipe   <= {rd_pipe[0], vid_req};
    end
  end

  assign vid_rvalid = rd_pipe[1];
  assign vid_rdata  = rd_pipe[1] ? mem_rdata : '0;

`ifdef FB_ARB_STATS_EN
  logic       stall;
  logic [7:0] stall_run;
  logic [7:0] stall_run_nxt;

  assign stall         = vid_req && !empty;
  assign stall_run_nxt = !stall ? 8'd0 :
                         (stall_run == 8'hFF) ? 8'hFF : stall_run + 8'd1;

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      stat_wr_count  <= '0;
      stat_max_stall <= '0;
      stall_run      <= '0;
    end else begin
      stall_run <= stall_run_nxt;
      if (pop) stat_wr_count <= stat_wr_count + 16'd1;
      if (stall_run_nxt > stat_max_stall) stat_max_stall <= stall_run_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural single-port RAM model;
// statistics checks are compiled in when FB_ARB_STATS_EN is defined.
module tb_fb_arbiter;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 4;

  logic              clk25 = 1'b0;
  logic              reset_n;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_rvalid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [2:0]        fifo_level;
`ifdef FB_ARB_STATS_EN
  logic [15:0]       stat_wr_count;
  logic [7:0]        stat_max_stall;
`endif

  int total = 0;
  int bad   = 0;

  fb_arbiter dut (
    .clk25      (clk25),
    .reset_n    (reset_n),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_rdata  (vid_rdata),
    .vid_rvalid (vid_rvalid),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
`ifdef FB_ARB_STATS_EN
    .stat_wr_count  (stat_wr_count),
    .stat_max_stall (stat_max_stall),
`endif
    .fifo_level (fifo_level)
  );

  initial forever #5 clk25 = ~clk25;

  // Unwritten RAM words hold a fixed address-derived pattern.
  function automatic logic [3:0] pattern(input logic [ADDR_W-1:0] a);
    return a[3:0] ^ a[7:4] ^ 4'h5;
  endfunction

  logic [3:0] ram [int];
  int acc_cnt = 0;
  int wr_cnt  = 0;
  int wq_addr [$];
  int wq_data [$];

  always @(posedge clk25) begin
    if (mem_en) begin
      acc_cnt = acc_cnt + 1;
      if (mem_we) begin
        ram[int'(mem_addr)] = mem_wdata;
        wr_cnt = wr_cnt + 1;
        wq_addr.push_back(int'(mem_addr));
        wq_data.push_back(int'(mem_wdata));
      end else begin
        mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : pattern(mem_addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected scanout data: address 0x10 is rewritten to 0xF early in the run.
  function automatic logic [3:0] exp_rd(input int a);
    return (a == 'h10) ? 4'hF : pattern(ADDR_W'(a));
  endfunction

  initial begin
    int   acc, rv_cnt, bad_cyc, cnt0, base, acc0, leak;
    logic take, exp_v;

    reset_n = 1'b0; vid_req = 1'b0; vid_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    check("rst_level",  32'(fifo_level), 0);
    check("rst_ready",  32'(wr_ready),   0);
    check("rst_en",     32'(mem_en),     0);
    check("rst_we",     32'(mem_we),     0);
    check("rst_addr",   32'(mem_addr),   0);
    check("rst_wdata",  32'(mem_wdata),  0);
    check("rst_rvalid", 32'(vid_rvalid), 0);
    check("rst_rdata",  32'(vid_rdata),  0);
    reset_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(wr_ready), 1);

    // Single write from idle reaches the RAM two cycles after the push.
    wr_valid = 1'b1; wr_addr = 18'h00010; wr_data = 4'hF;
    tick();
    wr_valid = 1'b0;
    check("w1_level_t1", 32'(fifo_level), 1);
    check("w1_en_t1",    32'(mem_en),     0);
    tick();
    check("w1_en",    32'(mem_en),    1);
    check("w1_we",    32'(mem_we),    1);
    check("w1_addr",  32'(mem_addr),  'h10);
    check("w1_wdata", 32'(mem_wdata), 'hF);
    check("w1_level", 32'(fifo_level), 0);
    tick();
    check("w1_idle_en", 32'(mem_en), 0);
    check("w1_idle_we", 32'(mem_we), 0);

    // 472-cycle scanout burst while six writes are offered.
    base = wq_addr.size(); cnt0 = wr_cnt; acc = 0; rv_cnt = 0; bad_cyc = 0;
    for (int i = 0; i < 474; i++) begin
      vid_req  = (i < 472);
      vid_addr = (i < 472) ? ADDR_W'(i) : '0;
      wr_valid = (i < 472);
      wr_addr  = ADDR_W'('h1000 + acc);
      wr_data  = DATA_W'(acc + 1);
      take     = wr_valid && wr_ready;
      tick();
      if (take) acc++;
      exp_v = (i >= 1 && i <= 472);
      if (vid_rvalid) rv_cnt++;
      if (vid_rvalid !== exp_v || vid_rdata !== (exp_v ? exp_rd(i - 1) : 4'h0)) bad_cyc++;
      if (i == 471) begin
        check("burst_level", 32'(fifo_level), 4);
        check("burst_ready", 32'(wr_ready),   0);
        check("burst_no_wr", 32'(wr_cnt - cnt0), 0);
      end
    end
    wr_valid = 1'b0;
    check("burst_accepted", 32'(acc),     4);
    check("burst_rv_cnt",   32'(rv_cnt),  472);
    check("burst_rd_cycles_bad", 32'(bad_cyc), 0);
    repeat (4) tick();
    check("drain_level", 32'(fifo_level), 0);
    check("drain_count", 32'(wq_addr.size() - base), 4);
    for (int k = 0; k < 4 && base + k < wq_addr.size(); k++) begin
      check("drain_addr", 32'(wq_addr[base + k]), 32'('h1000 + k));
      check("drain_data", 32'(wq_data[base + k]), 32'(k + 1));
    end

    // Push and pop together at level 2; read of a buffered address sees old data.
    base = wq_addr.size();
    vid_req = 1'b1; vid_addr = 18'h00010;
    wr_valid = 1'b1; wr_addr = 18'h02000; wr_data = 4'h7;
    tick();
    check("pp_level_a", 32'(fifo_level), 1);
    vid_addr = 18'h02000; wr_addr = 18'h02001; wr_data = 4'h8;
    tick();
    check("pp_level_b", 32'(fifo_level), 2);
    check("pp_rvalid_a", 32'(vid_rvalid), 1);
    check("pp_rdata_a",  32'(vid_rdata),  'hF);
    vid_req = 1'b0; wr_addr = 18'h02002; wr_data = 4'h9;
    tick();
    wr_valid = 1'b0;
    check("pp_level_same", 32'(fifo_level), 2);
    check("pp_rvalid_b", 32'(vid_rvalid), 1);
    check("pp_no_fwd",   32'(vid_rdata),  'h5);
    repeat (4) tick();
    check("pp_level_end", 32'(fifo_level), 0);
    check("pp_count", 32'(wq_addr.size() - base), 3);
    for (int k = 0; k < 3 && base + k < wq_addr.size(); k++) begin
      check("pp_order_addr", 32'(wq_addr[base + k]), 32'('h2000 + k));
      check("pp_order_data", 32'(wq_data[base + k]), 32'(7 + k));
    end

    // Reset with three buffered writes and reads in flight.
    for (int k = 0; k < 3; k++) begin
      vid_req = 1'b1; vid_addr = ADDR_W'(k);
      wr_valid = 1'b1; wr_addr = ADDR_W'('h3000 + k); wr_data = DATA_W'(k);
      tick();
    end
    check("mid_level",  32'(fifo_level), 3);
    check("mid_rvalid", 32'(vid_rvalid), 1);
    vid_req = 1'b0; wr_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mr_level",  32'(fifo_level), 0);
    check("mr_rvalid", 32'(vid_rvalid), 0);
    check("mr_en",     32'(mem_en),     0);
    check("mr_ready",  32'(wr_ready),   0);
    acc0 = acc_cnt;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("mr_ready_rel", 32'(wr_ready),   1);
    check("mr_level_rel", 32'(fifo_level), 0);
    leak = 0;
    repeat (3) begin
      tick();
      if (vid_rvalid !== 1'b0 || mem_en !== 1'b0) leak++;
    end
    check("mr_quiet",  32'(leak), 0);
    check("mr_no_acc", 32'(acc_cnt - acc0), 0);

`ifdef FB_ARB_STATS_EN
    check("st_wr_rst",    32'(stat_wr_count),  0);
    check("st_stall_rst", 32'(stat_max_stall), 0);
    vid_req = 1'b1; vid_addr = '0;
    wr_valid = 1'b1; wr_addr = 18'h04000; wr_data = 4'h3;
    tick();
    wr_valid = 1'b0;
    repeat (100) tick();
    check("st_stall_100", 32'(stat_max_stall), 100);
    repeat (200) tick();
    check("st_stall_sat", 32'(stat_max_stall), 255);
    check("st_wr_none",   32'(stat_wr_count),  0);
    vid_req = 1'b0;
    tick(); tick();
    check("st_wr_one",    32'(stat_wr_count),  1);
    check("st_stall_hold", 32'(stat_max_stall), 255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
